// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, types and commit-count helper for the CPU core
package cpu_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int NREGS  = 8;
    localparam int CNT_W  = 16;

    typedef logic [ADDR_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0] word_t;

    // A dual write to one index commits a single register, so it counts once.
    function automatic logic [1:0] commit_inc(input logic lo_we, input logic hi_we, input logic same_idx);
        if (lo_we && hi_we && !same_idx)
            return 2'd2;
        else if (lo_we || hi_we)
            return 2'd1;
        else
            return 2'd0;
    endfunction

endpackage

// File: rtl/wb_read_bypass.sv
// rtl/wb_read_bypass.sv - one read port with write-to-read bypass, low port first
module wb_read_bypass
    import cpu_pkg::*;
#(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W
) (
    input  logic [ADDR_W-1:0] rsrc,
    input  logic              lo_we,
    input  logic [ADDR_W-1:0] lo_idx,
    input  logic [DATA_W-1:0] lo_data,
    input  logic              hi_we,
    input  logic [ADDR_W-1:0] hi_idx,
    input  logic [DATA_W-1:0] hi_data,
    input  logic [DATA_W-1:0] reg_data,
    output logic [DATA_W-1:0] rdata
);

    // Same priority as the commit path, so a colliding write reads as it will be stored.
    always_comb begin
        rdata = reg_data;
        if (lo_we && (rsrc == lo_idx))
            rdata = lo_data;
        else if (hi_we && (rsrc == hi_idx))
            rdata = hi_data;
    end

endmodule

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - writeback register file: dual commit, bypassed reads, commit counter
module wb_regfile
    import cpu_pkg::*;
#(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int NREGS  = cpu_pkg::NREGS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] Rdst1_in,
    input  logic [DATA_W-1:0] Rdst1_val_in,
    input  logic [DATA_W-1:0] Data_in,
    input  logic              memToReg_in,
    input  logic              reglow_write_in,
    input  logic [ADDR_W-1:0] Rdst2_in,
    input  logic [DATA_W-1:0] Rdst2_val_in,
    input  logic              reghigh_write_in,
    input  logic [ADDR_W-1:0] Rsrc1_addr,
    input  logic [ADDR_W-1:0] Rsrc2_addr,
    output logic [DATA_W-1:0] Rsrc1_data,
    output logic [DATA_W-1:0] Rsrc2_data,
    output logic [15:0]       wb_count,
    output logic              collision_err
);

    logic [DATA_W-1:0] regs [NREGS];
    logic [DATA_W-1:0] wd_low;
    logic              same_idx;

    assign wd_low   = memToReg_in ? Data_in : Rdst1_val_in;
    assign same_idx = (Rdst1_in == Rdst2_in);

    // High port is written first so the low port overrides it on a collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
            wb_count      <= '0;
            collision_err <= 1'b0;
        end else begin
            if (reghigh_write_in)
                regs[Rdst2_in] <= Rdst2_val_in;
            if (reglow_write_in)
                regs[Rdst1_in] <= wd_low;
            wb_count      <= wb_count + {{(CNT_W-2){1'b0}},
                                         commit_inc(reglow_write_in, reghigh_write_in, same_idx)};
            collision_err <= reglow_write_in && reghigh_write_in && same_idx;
        end
    end

    wb_read_bypass #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd1 (
        .rsrc     (Rsrc1_addr),
        .lo_we    (reglow_write_in),
        .lo_idx   (Rdst1_in),
        .lo_data  (wd_low),
        .hi_we    (reghigh_write_in),
        .hi_idx   (Rdst2_in),
        .hi_data  (Rdst2_val_in),
        .reg_data (regs[Rsrc1_addr]),
        .rdata    (Rsrc1_data)
    );

    wb_read_bypass #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd2 (
        .rsrc     (Rsrc2_addr),
        .lo_we    (reglow_write_in),
        .lo_idx   (Rdst1_in),
        .lo_data  (wd_low),
        .hi_we    (reghigh_write_in),
        .hi_idx   (Rdst2_in),
        .hi_data  (Rdst2_val_in),
        .reg_data (regs[Rsrc2_addr]),
        .rdata    (Rsrc2_data)
    );

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - scoreboard bench for wb_regfile with directed vectors
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  Rdst1_in, Rdst2_in, Rsrc1_addr, Rsrc2_addr;
    logic [15:0] Rdst1_val_in, Data_in, Rdst2_val_in;
    logic        memToReg_in, reglow_write_in, reghigh_write_in;
    logic [15:0] Rsrc1_data, Rsrc2_data, wb_count;
    logic        collision_err;

    typedef struct {
        logic [15:0] r1;
        logic [15:0] r2;
        logic [15:0] cnt;
        logic        coll;
    } exp_t;

    exp_t  exp_q [$];
    string name_q [$];
    int    checks = 0;
    int    passes = 0;

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk              (clk),
        .reset            (reset),
        .Rdst1_in         (Rdst1_in),
        .Rdst1_val_in     (Rdst1_val_in),
        .Data_in          (Data_in),
        .memToReg_in      (memToReg_in),
        .reglow_write_in  (reglow_write_in),
        .Rdst2_in         (Rdst2_in),
        .Rdst2_val_in     (Rdst2_val_in),
        .reghigh_write_in (reghigh_write_in),
        .Rsrc1_addr       (Rsrc1_addr),
        .Rsrc2_addr       (Rsrc2_addr),
        .Rsrc1_data       (Rsrc1_data),
        .Rsrc2_data       (Rsrc2_data),
        .wb_count         (wb_count),
        .collision_err    (collision_err)
    );

    task automatic check(input string nm, input string field, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act === req)
            passes++;
        else
            $display("FAIL %s.%s: got 0x%04h, expected 0x%04h", nm, field, act, req);
    endtask

    // Monitor: the DUT presents a fresh output every cycle; compare mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            check(nm, "Rsrc1_data", Rsrc1_data, e.r1);
            check(nm, "Rsrc2_data", Rsrc2_data, e.r2);
            check(nm, "wb_count", wb_count, e.cnt);
            check(nm, "collision_err", {15'd0, collision_err}, {15'd0, e.coll});
        end
    end

    task automatic drive(input logic rst, input logic lw, input logic [2:0] d1, input logic [15:0] v1,
                         input logic [15:0] dat, input logic m2r, input logic hw, input logic [2:0] d2,
                         input logic [15:0] v2, input logic [2:0] s1, input logic [2:0] s2);
        @(posedge clk);
        #1;
        reset            = rst;
        reglow_write_in  = lw;
        Rdst1_in         = d1;
        Rdst1_val_in     = v1;
        Data_in          = dat;
        memToReg_in      = m2r;
        reghigh_write_in = hw;
        Rdst2_in         = d2;
        Rdst2_val_in     = v2;
        Rsrc1_addr       = s1;
        Rsrc2_addr       = s2;
    endtask

    task automatic expect_out(input string nm, input logic [15:0] r1, input logic [15:0] r2,
                              input logic [15:0] cnt, input logic coll);
        exp_t e;
        e.r1 = r1; e.r2 = r2; e.cnt = cnt; e.coll = coll;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    initial begin
        reset = 1'b1;
        reglow_write_in = 1'b0; reghigh_write_in = 1'b0; memToReg_in = 1'b0;
        Rdst1_in = '0; Rdst2_in = '0; Rsrc1_addr = '0; Rsrc2_addr = '0;
        Rdst1_val_in = '0; Rdst2_val_in = '0; Data_in = '0;

        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0, 3'(i), 3'(i + 4));
            expect_out("reset_read", 16'h0000, 16'h0000, 16'd0, 1'b0);
        end

        drive(0, 1, 3, 16'h1234, 16'hBEEF, 1, 0, 0, 16'h0, 3, 0);
        expect_out("low_mem_bypass", 16'hBEEF, 16'h0000, 16'd0, 1'b0);
        drive(0, 1, 3, 16'h1234, 16'hBEEF, 0, 0, 0, 16'h0, 3, 3);
        expect_out("low_alu_bypass", 16'h1234, 16'h1234, 16'd1, 1'b0);
        drive(0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0, 3, 3);
        expect_out("low_alu_stored", 16'h1234, 16'h1234, 16'd2, 1'b0);

        drive(0, 1, 2, 16'h0011, 16'hFFFF, 0, 1, 5, 16'hAA55, 2, 5);
        expect_out("dual_bypass", 16'h0011, 16'hAA55, 16'd2, 1'b0);
        drive(0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0, 2, 5);
        expect_out("dual_stored", 16'h0011, 16'hAA55, 16'd4, 1'b0);

        drive(0, 1, 4, 16'h9999, 16'h1111, 1, 1, 4, 16'h2222, 4, 4);
        expect_out("coll_bypass", 16'h1111, 16'h1111, 16'd4, 1'b0);
        drive(0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0, 4, 4);
        expect_out("coll_pulse", 16'h1111, 16'h1111, 16'd5, 1'b1);
        drive(0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0, 4, 0);
        expect_out("coll_clear", 16'h1111, 16'h0000, 16'd5, 1'b0);

        drive(0, 0, 0, 16'h0, 16'h0, 0, 1, 6, 16'h7777, 6, 6);
        expect_out("high_bypass", 16'h7777, 16'h7777, 16'd5, 1'b0);
        drive(0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0, 6, 6);
        expect_out("high_stored", 16'h7777, 16'h7777, 16'd6, 1'b0);

        drive(0, 1, 7, 16'h0707, 16'h0, 0, 1, 1, 16'h0101, 7, 1);
        expect_out("split_bypass", 16'h0707, 16'h0101, 16'd6, 1'b0);
        drive(0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0, 7, 1);
        expect_out("split_stored", 16'h0707, 16'h0101, 16'd8, 1'b0);

        drive(0, 1, 0, 16'hABCD, 16'h0, 0, 0, 0, 16'h0, 0, 2);
        expect_out("reg0_bypass", 16'hABCD, 16'h0011, 16'd8, 1'b0);
        drive(0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0, 0, 3);
        expect_out("reg0_stored", 16'hABCD, 16'h1234, 16'd9, 1'b0);

        // 9 + 2*32763 = 0xFFFF
        for (int i = 0; i < 32763; i++)
            drive(0, 1, 6, 16'h6666, 16'h0, 0, 1, 7, 16'h7777, 0, 0);

        drive(0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0, 6, 7);
        expect_out("preload_full", 16'h6666, 16'h7777, 16'hFFFF, 1'b0);
        drive(0, 1, 2, 16'h2222, 16'h0, 0, 1, 5, 16'h5555, 2, 5);
        expect_out("wrap_dual", 16'h2222, 16'h5555, 16'hFFFF, 1'b0);
        drive(0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0, 2, 5);
        expect_out("wrap_result", 16'h2222, 16'h5555, 16'h0001, 1'b0);

        drive(1, 1, 1, 16'h5A5A, 16'h0, 0, 0, 0, 16'h0, 1, 1);
        expect_out("reset_bypass", 16'h5A5A, 16'h5A5A, 16'h0001, 1'b0);
        drive(0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0, 1, 2);
        expect_out("reset_wins", 16'h0000, 16'h0000, 16'h0000, 1'b0);

        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() == 0)
            passes++;
        else
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
